// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the Avalon-MM BCD time-of-day clock.
// Register map, CTRL/STATUS bit positions, BCD limits, seg7 decode and BCD check.
package rtc_pkg;

  localparam logic [1:0] ADDR_TIME   = 2'd0;
  localparam logic [1:0] ADDR_ALARM  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_AEN   = 1;
  localparam int CTRL_BLANK = 2;

  localparam int ST_HIT = 0;
  localparam int ST_ERR = 1;

  localparam logic [7:0] SS_MAX = 8'h59;
  localparam logic [7:0] HH_MAX = 8'h23;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Byte compares are only meaningful once every nibble is decimal.
  function automatic logic bcd_valid(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    if (t[7:0] > SS_MAX) ok = 1'b0;
    if (t[15:8] > SS_MAX) ok = 1'b0;
    if (t[23:16] > HH_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit counter: load beats increment, wraps MAX->0 with carry.
// Ports: clk, reset (sync), load/din, inc -> q, carry (combinational).
module bcd_digit_ctr #(
  parameter logic [3:0] MAX = 4'd9,
  parameter logic [3:0] RST = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q, q_d;

  assign q     = q_q;
  assign carry = inc & (q_q == MAX);

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (inc) begin
      q_d = carry ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RST;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/avalon_rtc_hex.sv
// Avalon-MM HH:MM:SS BCD clock with alarm irq and direct 7-segment drive.
// Ports: Avalon slave (chipselect/address/read/write/writedata/readdata), irq, hex0..hex5.
module avalon_rtc_hex
  import rtc_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter logic [23:0] RESET_TIME = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
  localparam logic [23:0] T_LAST = {HH_MAX, SS_MAX, SS_MAX};

  logic [PW-1:0] pre_q, pre_d;
  logic run_q, run_d, aen_q, aen_d, blank_q, blank_d;
  logic [23:0] time_q, alarm_q, alarm_d;
  logic hit_q, hit_d, err_q, err_d;
  logic irq_q, irq_d, evt_q, evt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [5:0][7:0] hex_q, hex_d;

  logic wr_en, rd_en;
  logic wr_time, wr_alarm, wr_ctrl, wr_stat;
  logic wd_ok, time_ld, tick, step, hr_wrap, colon;
  logic [5:0] inc, carry, ld;
  logic [23:0] din;

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign wr_time  = wr_en & (address == ADDR_TIME);
  assign wr_alarm = wr_en & (address == ADDR_ALARM);
  assign wr_ctrl  = wr_en & (address == ADDR_CTRL);
  assign wr_stat  = wr_en & (address == ADDR_STATUS);
  assign wd_ok    = bcd_valid(writedata[23:0]);
  assign time_ld  = wr_time & wd_ok;

  assign tick    = run_q & (pre_q == PRE_LAST);
  // A valid TIME write swallows a coincident tick.
  assign step    = tick & ~time_ld;
  assign hr_wrap = step & (time_q == T_LAST);
  assign colon   = run_q & (pre_q < PRE_HALF);

  // Digit chain: ss ones .. hh tens. Hours restart together at 23->00.
  assign inc = {carry[4:0], step};
  assign din = time_ld ? writedata[23:0] : 24'h0;
  assign ld  = {{2{time_ld | hr_wrap | carry[5]}}, {4{time_ld}}};

  for (genvar i = 0; i < 6; i++) begin : g_dig
    localparam logic [3:0] M =
      (i == 5) ? 4'd2 : ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
    bcd_digit_ctr #(
      .MAX(M),
      .RST(RESET_TIME[4*i +: 4])
    ) u_dig (
      .clk  (clk),
      .reset(reset),
      .load (ld[i]),
      .din  (din[4*i +: 4]),
      .inc  (inc[i]),
      .q    (time_q[4*i +: 4]),
      .carry(carry[i])
    );
  end

  always_comb begin
    pre_d   = pre_q;
    run_d   = run_q;
    aen_d   = aen_q;
    blank_d = blank_q;
    alarm_d = alarm_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;

    if (time_ld || tick) begin
      pre_d = '0;
    end else if (run_q) begin
      pre_d = pre_q + PW'(1);
    end

    if (wr_ctrl) begin
      run_d   = writedata[CTRL_RUN];
      aen_d   = writedata[CTRL_AEN];
      blank_d = writedata[CTRL_BLANK];
    end

    if (wr_alarm && wd_ok) begin
      alarm_d = writedata[23:0];
    end

    // The compare runs the cycle after the time changed; set beats W1C.
    evt_d = time_ld | step;
    hit_d = (hit_q & ~(wr_stat & writedata[ST_HIT]))
          | (evt_q & aen_q & (time_q == alarm_q));
    err_d = (err_q & ~(wr_stat & writedata[ST_ERR]))
          | ((wr_time | wr_alarm) & ~wd_ok);
    irq_d = hit_q & aen_q;

    if (rd_en) begin
      rdata_d = '0;
      unique case (address)
        ADDR_TIME:   rdata_d[23:0] = time_q;
        ADDR_ALARM:  rdata_d[23:0] = alarm_q;
        ADDR_CTRL: begin
          rdata_d[CTRL_RUN]   = run_q;
          rdata_d[CTRL_AEN]   = aen_q;
          rdata_d[CTRL_BLANK] = blank_q;
        end
        ADDR_STATUS: begin
          rdata_d[ST_HIT] = hit_q;
          rdata_d[ST_ERR] = err_q;
        end
      endcase
    end

    for (int i = 0; i < 6; i++) begin
      hex_d[i] = {1'b1, seg7(time_q[4*i +: 4])};
      if (i == 2 || i == 4) hex_d[i][7] = ~colon;
      if (blank_q) hex_d[i] = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      run_q   <= 1'b0;
      aen_q   <= 1'b0;
      blank_q <= 1'b0;
      alarm_q <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      evt_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < 6; i++) begin
        hex_q[i] <= {1'b1, seg7(RESET_TIME[4*i +: 4])};
      end
    end else begin
      pre_q   <= pre_d;
      run_q   <= run_d;
      aen_q   <= aen_d;
      blank_q <= blank_d;
      alarm_q <= alarm_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      evt_q   <= evt_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;
  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];

endmodule

// File: tb/tb_avalon_rtc_hex.sv
// Bench for avalon_rtc_hex: seconds-of-day model checked every cycle,
// plus directed register scenarios with literal expectations.
module tb_avalon_rtc_hex;

  localparam int HZ = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [7:0]  hx [6];

  avalon_rtc_hex #(
    .CLK_HZ(HZ),
    .RESET_TIME(24'h000000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .hex4      (hex4),
    .hex5      (hex5)
  );

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // ---- model: time and alarm held as seconds since midnight ----
  logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int from_bcd(input logic [23:0] v);
    int d [6];
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[4*i +: 4]);
      if (d[i] > 9) return -1;
    end
    if (d[5]*10 + d[4] > 23) return -1;
    if (d[3]*10 + d[2] > 59) return -1;
    if (d[1]*10 + d[0] > 59) return -1;
    return (d[5]*10 + d[4]) * 3600 + (d[3]*10 + d[2]) * 60 + d[1]*10 + d[0];
  endfunction

  int m_secs, m_pre, m_alarm, wv;
  bit m_run, m_aen, m_blank, m_hit, m_err, m_irq, m_evt, mvalid;
  bit tk, col, mt, ev, twr, awr, cwr, swr, nh, ne;
  logic [31:0] m_rd;
  logic [7:0]  m_hex [6];
  logic [23:0] tb_t;

  always @(posedge clk) begin
    if (reset) begin
      m_secs = 0; m_pre = 0; m_alarm = 0;
      m_run = 0; m_aen = 0; m_blank = 0;
      m_hit = 0; m_err = 0; m_irq = 0; m_evt = 0;
      m_rd = 32'h0;
      for (int i = 0; i < 6; i++) m_hex[i] = {1'b1, SEG[0]};
      mvalid = 1;
    end else begin
      tb_t = to_bcd(m_secs);
      tk  = m_run && (m_pre == HZ - 1);
      col = m_run && (m_pre < HZ / 2);
      for (int i = 0; i < 6; i++) begin
        if (m_blank) m_hex[i] = 8'hFF;
        else m_hex[i] = {(i == 2 || i == 4) ? !col : 1'b1,
                         SEG[tb_t[4*i +: 4]]};
      end
      mt = m_evt && m_aen && (m_secs == m_alarm);
      nh = m_hit && m_aen;
      if (chipselect && read) begin
        case (address)
          2'd0: m_rd = {8'h0, tb_t};
          2'd1: m_rd = {8'h0, to_bcd(m_alarm)};
          2'd2: m_rd = {29'h0, m_blank, m_aen, m_run};
          default: m_rd = {30'h0, m_err, m_hit};
        endcase
      end
      wv  = from_bcd(writedata[23:0]);
      twr = chipselect && write && address == 2'd0;
      awr = chipselect && write && address == 2'd1;
      cwr = chipselect && write && address == 2'd2;
      swr = chipselect && write && address == 2'd3;
      ev  = 0;
      if (twr && wv >= 0) begin
        m_secs = wv; m_pre = 0; ev = 1;
      end else if (tk) begin
        m_secs = (m_secs + 1) % 86400; m_pre = 0; ev = 1;
      end else if (m_run) begin
        m_pre++;
      end
      ne = (m_err && !(swr && writedata[1])) || ((twr || awr) && wv < 0);
      if (awr && wv >= 0) m_alarm = wv;
      if (cwr) begin
        m_run = writedata[0]; m_aen = writedata[1]; m_blank = writedata[2];
      end
      m_hit = (m_hit && !(swr && writedata[0])) || mt;
      m_err = ne;
      m_irq = nh;
      m_evt = ev;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("readdata", readdata, m_rd);
      chk("irq", 32'(irq), 32'(m_irq));
      for (int i = 0; i < 6; i++) chk($sformatf("hex%0d", i), 32'(hx[i]), 32'(m_hex[i]));
    end
  end

  // ---- bus helpers: called #1 after a rising edge ----
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1; read = 1; address = a;
    @(posedge clk); #1;
    chipselect = 0; read = 0;
    d = readdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rv;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // 1: run ten ticks from midnight
    bus_write(2'd2, 32'h1);
    cyc(100);
    bus_read(2'd0, rv);
    chk("t1_time", rv, 32'h000010);
    chk("t1_hex0", 32'(hex0), 32'hC0);
    chk("t1_hex1", 32'(hex1), 32'hF9);

    // 2: midnight rollover
    bus_write(2'd2, 32'h0);
    bus_write(2'd0, 32'h235958);
    bus_write(2'd2, 32'h1);
    cyc(10);
    bus_read(2'd0, rv);
    chk("t2_235959", rv, 32'h235959);
    cyc(9);
    bus_read(2'd0, rv);
    chk("t2_wrap", rv, 32'h000000);

    // 3: rejected writes and SET_ERR clear
    bus_write(2'd2, 32'h0);
    bus_write(2'd0, 32'h101010);
    bus_write(2'd0, 32'h126000);
    bus_write(2'd1, 32'h0000AA);
    bus_read(2'd0, rv);
    chk("t3_time_kept", rv, 32'h101010);
    bus_read(2'd1, rv);
    chk("t3_alarm_kept", rv, 32'h0);
    bus_read(2'd3, rv);
    chk("t3_set_err", rv, 32'h2);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rv);
    chk("t3_err_clr", rv, 32'h0);

    // 4: alarm, W1C, AEN masking
    bus_write(2'd1, 32'h000005);
    bus_write(2'd0, 32'h000003);
    bus_write(2'd2, 32'h3);
    cyc(25);
    chk("t4_irq_set", 32'(irq), 32'h1);
    bus_read(2'd3, rv);
    chk("t4_hit", rv, 32'h1);
    bus_write(2'd3, 32'h1);
    cyc(1);
    chk("t4_irq_clr", 32'(irq), 32'h0);
    bus_write(2'd0, 32'h000005);
    cyc(2);
    chk("t4_irq_wr", 32'(irq), 32'h1);
    bus_write(2'd2, 32'h1);
    cyc(1);
    chk("t4_irq_aen0", 32'(irq), 32'h0);
    bus_read(2'd3, rv);
    chk("t4_hit_kept", rv, 32'h1);

    // 5: TIME write lands on the tick cycle
    bus_write(2'd2, 32'h0);
    bus_write(2'd0, 32'h000000);
    bus_write(2'd2, 32'h1);
    cyc(9);
    bus_write(2'd0, 32'h120000);
    cyc(9);
    bus_read(2'd0, rv);
    chk("t5_no_inc", rv, 32'h120000);
    bus_read(2'd0, rv);
    chk("t5_next_tick", rv, 32'h120001);

    // 6: blank, streaming reads across a tick, reset mid-run
    bus_write(2'd2, 32'h7);
    bus_write(2'd0, 32'h000005);
    cyc(2);
    chk("t6_irq", 32'(irq), 32'h1);
    chk("t6_blank", 32'(hex0), 32'hFF);
    chipselect = 1; read = 1; address = 2'd0;
    cyc(15);
    chipselect = 0; read = 0;
    cyc(3);
    reset = 1;
    cyc(1);
    chk("t6_rst_rd", readdata, 32'h0);
    chk("t6_rst_irq", 32'(irq), 32'h0);
    chk("t6_rst_hex0", 32'(hex0), 32'hC0);
    chk("t6_rst_hex2", 32'(hex2), 32'hC0);
    reset = 0;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
